// File: rtl/serializer_pkg.sv
// Shared types and elaboration helpers for the lane serializer.
package serializer_pkg;

   typedef enum logic [1:0] {
      EMPTY  = 2'd0,
      ACTIVE = 2'd1,
      FULL   = 2'd2
   } ser_state_t;

   // Counter width that never collapses to zero bits when only one beat exists.
   function automatic int safe_clog2(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic bit lanes_ok(input int word_w, input int lane_w);
      return (lane_w >= 1) && (lane_w <= word_w) && ((word_w % lane_w) == 0);
   endfunction

endpackage

// File: rtl/serializer_lanes.sv
// Splits WORD_W-bit words into LANE_W-bit beats; a shift register plus one
// holding register lets consecutive words stream without idle cycles.
module serializer_lanes
   import serializer_pkg::*;
#(
   parameter int WORD_W = 24,
   parameter int LANE_W = 1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_en,
   input  logic [WORD_W-1:0] iv_din,
   input  logic              i_din_valid,
   input  logic              i_msb_first,
   output logic              o_din_ready,
   output logic [LANE_W-1:0] ov_dout,
   output logic              o_dout_valid,
   input  logic              i_dout_ready,
   output logic              o_dout_first,
   output logic              o_dout_last,
   output logic              o_busy
);

   localparam int N     = WORD_W / LANE_W;
   localparam int CNT_W = safe_clog2(N);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

   if (!lanes_ok(WORD_W, LANE_W)) begin : g_bad_lanes
      $error("serializer_lanes: WORD_W must be a non-zero multiple of LANE_W");
   end

   ser_state_t        state;
   logic [WORD_W-1:0] shift;
   logic [WORD_W-1:0] hold;
   logic [WORD_W-1:0] shift_adv;
   logic              shift_msb;
   logic              hold_msb;
   logic [CNT_W-1:0]  beat_cnt;
   logic              live;
   logic              take;
   logic              xfer;
   logic              at_last;

   // live keeps o_din_ready low until the first edge after reset release.
   assign o_din_ready  = i_en & live & (state != FULL);
   assign o_dout_valid = i_en & (state != EMPTY);
   assign o_busy       = (state != EMPTY);

   assign take    = i_din_valid & o_din_ready;
   assign xfer    = o_dout_valid & i_dout_ready;
   assign at_last = (beat_cnt == LAST_CNT);

   // The current beat always sits at the end of shift facing the word's order.
   assign ov_dout   = shift_msb ? shift[WORD_W-1 -: LANE_W] : shift[LANE_W-1:0];
   assign shift_adv = shift_msb ? (shift << LANE_W) : (shift >> LANE_W);

   assign o_dout_first = o_dout_valid & (beat_cnt == '0);
   assign o_dout_last  = o_dout_valid & at_last;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= EMPTY;
         shift     <= '0;
         hold      <= '0;
         shift_msb <= 1'b0;
         hold_msb  <= 1'b0;
         beat_cnt  <= '0;
         live      <= 1'b0;
      end else begin
         live <= 1'b1;
         if (i_en) begin
            if (xfer && !at_last) begin
               shift    <= shift_adv;
               beat_cnt <= beat_cnt + CNT_W'(1);
            end
            unique case (state)
               EMPTY: begin
                  if (take) begin
                     shift     <= iv_din;
                     shift_msb <= i_msb_first;
                     beat_cnt  <= '0;
                     state     <= ACTIVE;
                  end
               end
               ACTIVE: begin
                  if (xfer && at_last) begin
                     if (take) begin
                        shift     <= iv_din;
                        shift_msb <= i_msb_first;
                        beat_cnt  <= '0;
                     end else begin
                        state <= EMPTY;
                     end
                  end else if (take) begin
                     hold     <= iv_din;
                     hold_msb <= i_msb_first;
                     state    <= FULL;
                  end
               end
               FULL: begin
                  if (xfer && at_last) begin
                     shift     <= hold;
                     shift_msb <= hold_msb;
                     beat_cnt  <= '0;
                     state     <= ACTIVE;
                  end
               end
               default: state <= EMPTY;
            endcase
         end
      end
   end

endmodule
